// File: rtl/cla28_serial_sched.sv
// Two-requester adder that pushes each operand pair through one shared SLICE-bit
// carry-lookahead slice, one slice per cycle, under round-robin arbitration.
module cla28_serial_sched #(
  parameter int WIDTH = 28,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_id,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             id_q;
  logic             pref_q;
  logic             out_valid_q;
  logic [IDXW-1:0]  idx_q;

  logic             gnt_id;
  logic [1:0]       hs;

  // pref_q names the requester that wins the next contention; cleared to 0.
  always_comb begin
    gnt_id    = (req_valid == 2'b11) ? pref_q : req_valid[1];
    req_ready = 2'b00;
    if (rst_n && (state_q == IDLE)) begin
      req_ready = gnt_id ? {req_valid[1], 1'b0} : {1'b0, req_valid[0]};
    end
  end

  assign hs = req_valid & req_ready;

  logic [SLICE-1:0] sl_a, sl_b, sl_p, sl_g, sl_sum;
  logic [SLICE:0]   sl_c;

  // Operands shift down each RUN cycle, so the active slice is always the low bits.
  assign sl_a = a_q[SLICE-1:0];
  assign sl_b = b_q[SLICE-1:0];

  generate
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
      assign sl_p[gi]   = sl_a[gi] | sl_b[gi];
      assign sl_g[gi]   = sl_a[gi] & sl_b[gi];
      assign sl_sum[gi] = sl_a[gi] ^ sl_b[gi] ^ sl_c[gi];
    end
  endgenerate

  // Each carry is a flat sum of generate terms gated by the propagates above them;
  // sl_c[SLICE] is the group carry G | (P & carry_q).
  always_comb begin
    logic gen_acc;
    logic prop_acc;
    sl_c     = '0;
    gen_acc  = 1'b0;
    prop_acc = 1'b1;
    for (int j = 0; j <= SLICE; j++) begin
      gen_acc  = 1'b0;
      prop_acc = 1'b1;
      for (int k = j - 1; k >= 0; k--) begin
        gen_acc  = gen_acc | (sl_g[k] & prop_acc);
        prop_acc = prop_acc & sl_p[k];
      end
      sl_c[j] = gen_acc | (prop_acc & carry_q);
    end
  end

  assign carry_d = sl_c[SLICE];
  assign sum_d   = {sl_sum, sum_q[WIDTH-1:SLICE]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      id_q        <= 1'b0;
      pref_q      <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs != 2'b00) begin
            a_q     <= gnt_id ? req_a1 : req_a0;
            b_q     <= gnt_id ? req_b1 : req_b0;
            carry_q <= req_cin[gnt_id];
            id_q    <= gnt_id;
            pref_q  <= ~gnt_id;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> SLICE;
          b_q     <= b_q >> SLICE;
          sum_q   <= sum_d;
          carry_q <= carry_d;
          if (idx_q == LAST_IDX) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;
  assign out_id    = id_q;
  assign busy      = (state_q == RUN) || (state_q == DONE);

endmodule

// File: tb/tb_cla28_serial_sched.sv
// Directed bench for cla28_serial_sched: cycle-level reference model plus
// hand-computed expectations for reset, ripple, contention, backpressure and abort.
`timescale 1ns/1ps
module tb_cla28_serial_sched;

  localparam int WIDTH  = 28;
  localparam int NSLICE = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]       req_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_id;
  logic             busy;

  cla28_serial_sched #(.WIDTH(WIDTH), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_cin(req_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: an accepted operation is just a+b+cin, valid NSLICE edges later.
  int               cyc = 0;
  logic             m_busy = 1'b0, m_valid = 1'b0, m_pref = 1'b0;
  logic             m_cout = 1'b0, m_id = 1'b0;
  logic [WIDTH-1:0] m_sum = '0;
  int               m_cnt = 0;

  function automatic logic [1:0] model_ready();
    if (!rst_n || m_busy) return 2'b00;
    case (req_valid)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return m_pref ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_pref <= 1'b0; m_cnt <= 0;
      m_sum <= '0; m_cout <= 1'b0; m_id <= 1'b0;
    end else if (!m_busy) begin
      if (model_ready() == 2'b01) begin
        m_busy <= 1'b1; m_cnt <= 0; m_id <= 1'b0; m_pref <= 1'b1;
        {m_cout, m_sum} <= {1'b0, req_a0} + {1'b0, req_b0} + 29'(req_cin[0]);
      end else if (model_ready() == 2'b10) begin
        m_busy <= 1'b1; m_cnt <= 0; m_id <= 1'b1; m_pref <= 1'b0;
        {m_cout, m_sum} <= {1'b0, req_a1} + {1'b0, req_b1} + 29'(req_cin[1]);
      end
    end else if (!m_valid) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == NSLICE) m_valid <= 1'b1;
    end else if (out_ready) begin
      m_busy <= 1'b0; m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("ready", {62'd0, req_ready}, {62'd0, model_ready()});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      chk("busy", {63'd0, busy}, {63'd0, m_busy});
      if (m_valid) begin
        chk("out_sum", {36'd0, out_sum}, {36'd0, m_sum});
        chk("out_cout", {63'd0, out_cout}, {63'd0, m_cout});
        chk("out_id", {63'd0, out_id}, {63'd0, m_id});
      end
    end
  end

  // Event log used by the directed checks.
  int               acc_cyc_q[$];
  logic             acc_id_q[$];
  int               rise_q[$];
  logic [WIDTH-1:0] res_sum_q[$];
  logic [WIDTH-1:0] mod_sum_q[$];
  logic             res_cout_q[$];
  logic             res_id_q[$];
  logic             ov_prev = 1'b0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      if ((req_valid & req_ready) != 2'b00) begin
        acc_cyc_q.push_back(cyc + 1);
        acc_id_q.push_back(req_ready[1]);
      end
      if (out_valid && !ov_prev) rise_q.push_back(cyc);
      if (out_valid && out_ready) begin
        res_sum_q.push_back(out_sum);
        mod_sum_q.push_back(m_sum);
        res_cout_q.push_back(out_cout);
        res_id_q.push_back(out_id);
        $display("txn id=%0d sum=0x%07h cout=%0d cycle=%0d", out_id, out_sum, out_cout, cyc);
      end
      ov_prev <= out_valid;
    end
  end

  task automatic wait_hs(output logic [1:0] hs);
    hs = 2'b00;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      if (hs != 2'b00) break;
    end
  endtask

  task automatic wait_res(input int n, input string name);
    for (int t = 0; t < 40 && res_sum_q.size() < n; t++) @(posedge clk);
    chk(name, 64'(res_sum_q.size()), 64'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] hs;
    int         t;
    int         nrise;

    rst_n = 1'b0; out_ready = 1'b1; req_valid = 2'b11;
    req_a0 = 28'h0FFFFFFF; req_b0 = 28'h0000001;
    req_a1 = 28'h1234567;  req_b1 = 28'h7654321;
    req_cin = 2'b10;

    // Reset held with both requesters asking.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {62'd0, req_ready}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sum", {36'd0, out_sum}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Contention: requester 0 first, requester 1 nine cycles later.
    wait_hs(hs);
    chk("cont_hs0", {62'd0, hs}, 64'h1);
    @(posedge clk); #1; req_valid = req_valid & ~hs;
    wait_hs(hs);
    chk("cont_hs1", {62'd0, hs}, 64'h2);
    @(posedge clk); #1; req_valid = req_valid & ~hs;
    wait_res(2, "cont_results");
    chk("cont_id0", {63'd0, acc_id_q[0]}, 64'd0);
    chk("cont_id1", {63'd0, acc_id_q[1]}, 64'd1);
    chk("cont_spacing", 64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'd9);
    chk("ripple_latency", 64'(rise_q[0] - acc_cyc_q[0]), 64'd7);
    chk("ripple_sum", {36'd0, res_sum_q[0]}, 64'h0000000);
    chk("ripple_cout", {63'd0, res_cout_q[0]}, 64'd1);
    chk("ripple_id", {63'd0, res_id_q[0]}, 64'd0);
    chk("ripple_model", {36'd0, mod_sum_q[0]}, 64'h0000000);
    chk("cin_latency", 64'(rise_q[1] - acc_cyc_q[1]), 64'd7);
    chk("cin_sum", {36'd0, res_sum_q[1]}, 64'h8888889);
    chk("cin_cout", {63'd0, res_cout_q[1]}, 64'd0);
    chk("cin_id", {63'd0, res_id_q[1]}, 64'd1);
    chk("cin_model", {36'd0, mod_sum_q[1]}, 64'h8888889);

    // Backpressure, with requester 1 waiting and requester 0 inputs disturbed in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    req_a0 = 28'h9ABCDEF; req_b0 = 28'h8765432;
    req_a1 = 28'hFFFFFFF; req_b1 = 28'hFFFFFFF;
    req_cin = 2'b10; req_valid = 2'b11;
    wait_hs(hs);
    chk("bp_hs", {62'd0, hs}, 64'h1);
    @(posedge clk); #1;
    req_valid = req_valid & ~hs;
    req_a0 = 28'h5555555; req_b0 = 28'h2AAAAAA; req_cin = 2'b11;
    t = 0;
    while (!out_valid && t < 30) begin @(negedge clk); t++; end
    chk("bp_seen", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_sum", {36'd0, out_sum}, 64'h2222221);
      chk("bp_cout", {63'd0, out_cout}, 64'd1);
      chk("bp_id", {63'd0, out_id}, 64'd0);
      chk("bp_ready", {62'd0, req_ready}, 64'd0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_idle_busy", {63'd0, busy}, 64'd0);
    chk("bp_idle_ready", {62'd0, req_ready}, 64'h2);
    @(posedge clk); #1; req_valid[1] = 1'b0;
    wait_res(4, "bp_results");
    chk("bp_model", {36'd0, mod_sum_q[2]}, 64'h2222221);
    chk("all_ones_sum", {36'd0, res_sum_q[3]}, 64'hFFFFFFF);
    chk("all_ones_cout", {63'd0, res_cout_q[3]}, 64'd1);
    chk("all_ones_id", {63'd0, res_id_q[3]}, 64'd1);
    chk("all_ones_latency", 64'(rise_q[3] - acc_cyc_q[3]), 64'd7);

    // Reset at slice index 3, then a fresh request from requester 1.
    @(posedge clk); #1;
    req_a0 = 28'h0F0F0F0; req_b0 = 28'h0F0F0F0; req_cin = 2'b00; req_valid = 2'b01;
    wait_hs(hs);
    chk("abort_hs", {62'd0, hs}, 64'h1);
    @(posedge clk); #1; req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0; req_valid = 2'b10;
    req_a1 = 28'h7FFFFFF; req_b1 = 28'h0000001;
    @(negedge clk);
    chk("abort_rst_ready", {62'd0, req_ready}, 64'd0);
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_sum", {36'd0, out_sum}, 64'd0);
    chk("abort_cout", {63'd0, out_cout}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    nrise = rise_q.size();
    chk("abort_no_result", 64'(nrise), 64'd4);
    wait_hs(hs);
    chk("new_hs", {62'd0, hs}, 64'h2);
    @(posedge clk); #1; req_valid = 2'b00;
    wait_res(5, "new_results");
    chk("new_rise_count", 64'(rise_q.size()), 64'd5);
    chk("new_sum", {36'd0, res_sum_q[4]}, 64'h8000000);
    chk("new_cout", {63'd0, res_cout_q[4]}, 64'd0);
    chk("new_id", {63'd0, res_id_q[4]}, 64'd1);
    chk("new_latency", 64'(rise_q[4] - acc_cyc_q[5]), 64'd7);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cla28_serial_sched.md
CLA28_SERIAL_SCHED -- requirements
Module: cla28_serial_sched

Interface
REQ-001 Parameter WIDTH, default 28: operand width in bits.
REQ-002 Parameter SLICE, default 4: bits processed per cycle by the shared CLA slice. WIDTH SHALL be an integer multiple of SLICE; NSLICE = WIDTH/SLICE (7 at defaults).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester accept strobe; at most one bit high in any cycle.
REQ-007 req_a0, req_b0  input  WIDTH each  requester 0 operands.
REQ-008 req_a1, req_b1  input  WIDTH each  requester 1 operands.
REQ-009 req_cin  input  2  per-requester carry-in.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  result consumer ready.
REQ-012 out_sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
REQ-013 out_cout  output  1  carry out of bit WIDTH-1.
REQ-014 out_id  output  1  index of the requester that owns the result.
REQ-015 busy  output  1  high in RUN and DONE states.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE only; any unused encoding SHALL return to IDLE on the next edge.
REQ-017 IDLE: req_ready[i] SHALL be high combinationally iff req_valid[i] is high and requester i holds the grant; a handshake is req_valid[i] and req_ready[i] high at the same edge.
REQ-018 Arbitration SHALL be round-robin: with a single valid requester, that requester is granted; with both valid, the requester not granted last is granted. The last-grant register SHALL reset so that requester 0 wins the first contention.
REQ-019 On handshake: operands, cin and id SHALL be latched, the slice index SHALL be set to 0, the carry register SHALL be set to cin, and the FSM SHALL go to RUN.
REQ-020 RUN: each edge SHALL process slice k (bits SLICE*k+SLICE-1 .. SLICE*k).
REQ-021 Each slice SHALL be computed as: P = a|b, G = a&b, per-bit carries by lookahead from the carry register, and sum = a^b^carry.
REQ-022 Each slice's sum SHALL be written into the result register, and the carry register SHALL be loaded with the slice group carry G03 | (P03 & carry).
REQ-023 After slice NSLICE-1 is processed, the FSM SHALL go to DONE. out_valid SHALL rise exactly NSLICE edges after the accepting edge (7 at defaults).
REQ-024 DONE: out_valid is high. out_sum, out_cout and out_id SHALL be held stable while out_ready is low.
REQ-025 DONE with out_ready high at an edge: the FSM SHALL go to IDLE. No request SHALL be accepted in that same cycle; minimum spacing between accepting edges is NSLICE+2 cycles.
REQ-026 req_ready SHALL be 0 in RUN and DONE. Requests arriving while busy SHALL wait, and requester inputs SHALL NOT disturb an operation in flight.
REQ-027 Slice-index wrap: the index SHALL NOT advance past NSLICE-1 and SHALL be ignored outside RUN.
REQ-028 out_cout SHALL equal the carry register after the last slice; out_sum bits not yet processed SHALL never be presented, because out_valid is low until DONE.

Reset
REQ-029 rst_n low at an edge SHALL, from any state including mid-RUN, force IDLE and clear out_valid, out_sum, out_cout, out_id, busy, the slice index, the carry register and the last-grant register (requester 0 favoured).
REQ-030 An operation interrupted by reset SHALL be discarded and produce no result.
REQ-031 req_ready SHALL be 0 during any cycle in which rst_n is low.

Verification
REQ-032 Reset check: hold rst_n low 3 cycles with both req_valid high -> req_ready=00, out_valid=0, busy=0, out_sum=0.
REQ-033 Full carry ripple: req0 a=0x0FFFFFFF, b=0x0000001, cin=0 -> out_valid exactly 7 edges after accept, out_sum=0x0000000, out_cout=1, out_id=0.
REQ-034 Carry-in only: req1 a=0x1234567, b=0x7654321, cin=1 -> out_sum=0x8888889, out_cout=0, out_id=1.
REQ-035 Contention: both valid from the first cycle after reset, out_ready=1 -> requester 0 is served first, then requester 1. Accepting edges are 9 cycles apart and out_id sequence is 0,1.
REQ-036 Backpressure: out_ready low 5 cycles in DONE -> out_valid and outputs stable for all 5 cycles, req_ready=00, then IDLE one edge after out_ready rises.
REQ-037 Mid-op reset: assert rst_n low at slice index 3, then issue a new request -> no out_valid from the aborted operation, and the new result is correct and arrives after 7 edges.
